spi_cmd_bridge: RTL and testbench

- Downstream companion of the SPI slave, running in the system clock domain.
- Consumes each completed 16-bit received word (slave `done`/`rdata`) and decodes it as a register read/write command.
- Executes the command on a simple req/ack register bus and returns status plus read data on `tx_data`, which drives the slave's `tdata` input.
- The response is shifted out during the next SPI frame.

---
 rtl/spi_cmd_bridge.sv | 122 ++++++++++++
 tb/tb_spi_cmd_bridge.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_bridge.sv
// SPI command bridge: decodes 16-bit words from the SPI slave into register
// bus reads/writes and builds the status/data response for the next frame.
module spi_cmd_bridge #(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter logic [6:0]  STATUS_ADDR = 7'h7F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_done,
  input  logic [15:0]       spi_rdata,
  input  logic              spi_ss,
  output logic [15:0]       tx_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ack,
  output logic              busy,
  output logic              err_irq
);

  typedef enum logic [1:0] {IDLE, DECODE, REQ, RESP} state_t;

  state_t      state;
  logic        d1, d2, d3;
  logic        ss1, ss_n_s;
  logic        rise;
  logic [15:0] cmd_q;
  logic [7:0]  frame_cnt;
  logic [7:0]  rdata_q;
  logic [7:0]  timer;
  logic        to_err, ovr_err, frame_to;

  assign rise = d2 & ~d3;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      d1        <= 1'b0;
      d2        <= 1'b0;
      d3        <= 1'b0;
      ss1       <= 1'b0;
      ss_n_s    <= 1'b0;
      cmd_q     <= '0;
      frame_cnt <= '0;
      rdata_q   <= '0;
      timer     <= '0;
      to_err    <= 1'b0;
      ovr_err   <= 1'b0;
      frame_to  <= 1'b0;
      err_irq   <= 1'b0;
      tx_data   <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      d1      <= spi_done;
      d2      <= d1;
      d3      <= d2;
      ss1     <= spi_ss;
      ss_n_s  <= ss1;
      err_irq <= to_err | ovr_err;

      case (state)
        IDLE: begin
          if (rise) begin
            cmd_q     <= spi_rdata;
            frame_cnt <= frame_cnt + 8'd1;
            state     <= DECODE;
          end
        end
        DECODE: begin
          if (cmd_q[14:8] == STATUS_ADDR) begin
            if (cmd_q[15]) begin
              if (cmd_q[0]) to_err  <= 1'b0;
              if (cmd_q[1]) ovr_err <= 1'b0;
            end
            rdata_q <= frame_cnt;
            state   <= RESP;
          end else begin
            bus_addr  <= ADDR_W'(cmd_q[14:8]);
            bus_we    <= cmd_q[15];
            bus_wdata <= cmd_q[7:0];
            bus_req   <= 1'b1;
            timer     <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          // ack is checked first so an ack on the expiry cycle is not an error
          if (bus_ack) begin
            rdata_q <= bus_we ? 8'h00 : bus_rdata;
            bus_req <= 1'b0;
            state   <= RESP;
          end else if (timer == 8'(TIMEOUT_CYC - 1)) begin
            bus_req  <= 1'b0;
            to_err   <= 1'b1;
            frame_to <= 1'b1;
            rdata_q  <= 8'hEE;
            state    <= RESP;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        RESP: begin
          tx_data  <= {1'b1, frame_to, ovr_err, ss_n_s, frame_cnt[3:0], rdata_q};
          frame_to <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A word arriving while busy is dropped; setting overrides a same-cycle clear
      if (rise && state != IDLE) ovr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_cmd_bridge.sv
// Scoreboard bench for spi_cmd_bridge: expected bus cycles and responses are
// queued by the stimulus and checked by an independent monitor.
module tb_spi_cmd_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_done = 1'b0;
  logic [15:0] spi_rdata = '0;
  logic        spi_ss = 1'b0;
  logic [15:0] tx_data;
  logic        bus_req, bus_we;
  logic [6:0]  bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        busy, err_irq;

  spi_cmd_bridge #(.ADDR_W(7), .TIMEOUT_CYC(8), .STATUS_ADDR(7'h7F)) dut (
    .clk(clk), .rst(rst), .spi_done(spi_done), .spi_rdata(spi_rdata),
    .spi_ss(spi_ss), .tx_data(tx_data), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .busy(busy), .err_irq(err_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [6:0] addr;
    logic [7:0] wdata;
    int         len;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [15:0] tx_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          drive_cyc = 0;
  int          last_resp_cyc = 0;
  int          ack_delay = -1;
  logic [7:0]  ack_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus slave: acks ack_delay cycles after seeing bus_req; negative means never
  always begin
    @(negedge clk);
    if (bus_req === 1'b1 && !rst && ack_delay >= 0) begin
      repeat (ack_delay) @(negedge clk);
      bus_ack   = 1'b1;
      bus_rdata = ack_rdata;
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_rdata = '0;
    end
  end

  // Monitor
  logic     prev_req = 1'b0, prev_busy = 1'b0;
  int       req_len = 0;
  bus_exp_t cur;
  always @(negedge clk) begin
    if (bus_req === 1'b1 && !prev_req) begin
      req_len = 1;
      if (bus_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL bus_unexpected: got req addr %h expected no request", bus_addr);
        cur = '{1'b0, 7'h00, 8'h00, 0};
      end else begin
        cur = bus_q.pop_front();
        check("bus_we", bus_we, cur.we);
        check("bus_addr", bus_addr, cur.addr);
        check("bus_wdata", bus_wdata, cur.wdata);
      end
    end else if (bus_req === 1'b1) begin
      req_len++;
    end
    if (bus_req !== 1'b1 && prev_req) check("bus_req_len", req_len, cur.len);
    if (!rst && prev_busy && busy === 1'b0) begin
      last_resp_cyc = cyc;
      if (tx_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected: got %h expected no response", tx_data);
      end else begin
        check("tx_data", tx_data, tx_q.pop_front());
      end
    end
    prev_req  = (bus_req === 1'b1);
    prev_busy = (busy === 1'b1);
  end

  task automatic send_word(input logic [15:0] w);
    @(posedge clk); #1;
    spi_rdata = w;
    spi_done  = 1'b1;
    drive_cyc = cyc;
    repeat (3) @(posedge clk);
    #1 spi_done = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy === 1'b1) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy still %b expected 0", busy);
    end
    repeat (4) @(posedge clk);
  endtask

  initial begin
    logic [7:0] c;
    int n;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx_data, 16'h0000);
    check("rst_req", bus_req, 1'b0);
    check("rst_we", bus_we, 1'b0);
    check("rst_addr", bus_addr, 7'h00);
    check("rst_wdata", bus_wdata, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_irq", err_irq, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Frame 1: write, ack after 2 cycles, read data ignored
    ack_delay = 2; ack_rdata = 8'hAB;
    bus_q.push_back('{1'b1, 7'h0A, 8'h5C, 3});
    tx_q.push_back(16'h8100);
    send_word(16'h8A5C);
    wait_idle();

    // Frame 2: read acked in first REQ cycle; response 6 edges after drive
    ack_delay = 0; ack_rdata = 8'h3C;
    bus_q.push_back('{1'b0, 7'h03, 8'h00, 1});
    tx_q.push_back(16'h823C);
    send_word(16'h0300);
    wait_idle();
    check("latency", last_resp_cyc - drive_cyc, 6);

    // Frame 3: no ack, timeout after 8 cycles
    ack_delay = -1;
    bus_q.push_back('{1'b0, 7'h11, 8'h00, 8});
    tx_q.push_back(16'hC3EE);
    send_word(16'h1100);
    wait_idle();
    check("irq_timeout", err_irq, 1'b1);

    // Frame 4: second word arrives during REQ and is dropped
    ack_delay = 5; ack_rdata = 8'h77;
    bus_q.push_back('{1'b0, 7'h05, 8'h00, 6});
    tx_q.push_back(16'hA477);
    send_word(16'h0500);
    send_word(16'h1234);
    wait_idle();
    check("irq_ovr", err_irq, 1'b1);

    // Frame 5: status write clears both sticky bits, no bus cycle
    tx_q.push_back(16'h8505);
    send_word(16'hFF03);
    wait_idle();
    check("irq_clear", err_irq, 1'b0);

    // Frames 6..256: status reads, counter wraps 255 -> 0
    for (n = 6; n <= 256; n++) begin
      c = n[7:0];
      tx_q.push_back({4'b1000, c[3:0], c});
      send_word(16'h7F00);
      wait_idle();
    end

    // Reset while bus_req is high
    ack_delay = -1;
    bus_q.push_back('{1'b0, 7'h02, 8'h00, 1});
    send_word(16'h0200);
    n = 0;
    while (bus_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_before_rst", bus_req, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_req", bus_req, 1'b0);
    check("rst_mid_tx", tx_data, 16'h0000);
    check("rst_mid_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);

    check("bus_q_empty", bus_q.size(), 0);
    check("tx_q_empty", tx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
